// File: rtl/spin_readout.sv
// spin_readout: run controller and phase readout for the coupled-cell oscillator array.
// Optional feature macro READOUT_SNAPSHOT_EN adds the SNAP register (offset 0x004).
`ifndef READOUT_ADDR_MASK
`define READOUT_ADDR_MASK 8'h43
`endif

module spin_readout #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         axi_rstn,
    input  logic         wready,
    input  logic [31:0]  wr_addr,
    input  logic [31:0]  wdata,
    input  logic [31:0]  rd_addr,
    output logic [31:0]  rdata,
    input  logic [N-1:0] osc_in,
    output logic         ising_rstn
);
    typedef enum logic [2:0] {IDLE, HOLD, SETTLE, SAMPLE, DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic             busy, done;
    logic [N-1:0]     s_p0, s_p1;
    logic [CNT_W-1:0] settle_r, window_r, settle_l, window_l, settle_eff, phase_cnt;
    logic [CNT_W-1:0] mismatch     [N];
    logic [CNT_W-1:0] mismatch_nxt [N];
    logic [N-1:0]     spins;
    logic             wr_sel, rd_sel, ctrl_wr, start, abort, phase_last;
    logic             hold_entry, done_entry;
    logic [9:0]       wr_off, rd_off;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && v != CNT_MAX) return v + CNT_W'(1);
        return v;
    endfunction

    assign wr_sel      = (wr_addr[31:24] == `READOUT_ADDR_MASK);
    assign rd_sel      = (rd_addr[31:24] == `READOUT_ADDR_MASK);
    assign wr_off      = wr_addr[11:2];
    assign rd_off      = rd_addr[11:2];
    assign unused_bits = ^{wr_addr, rd_addr, wdata};
    assign ctrl_wr     = wready && wr_sel && (wr_off == 10'h000);
    assign abort       = ctrl_wr && wdata[1];
    assign start       = ctrl_wr && wdata[0] && !wdata[1];
    assign settle_eff  = (settle_l == '0) ? CNT_W'(1) : settle_l;

    // Two-flop synchronizer stage (osc_in is asynchronous)
    always_ff @(posedge clk) begin
        s_p0 <= osc_in;
        s_p1 <= s_p0;
    end

    always_comb begin
        phase_last = 1'b0;
        case (state)
            HOLD:    phase_last = (phase_cnt == CNT_W'(3));
            SETTLE:  phase_last = (phase_cnt == settle_eff - CNT_W'(1));
            SAMPLE:  phase_last = (phase_cnt == window_l - CNT_W'(1));
            default: phase_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!axi_rstn) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = HOLD;
                HOLD:       if (phase_last) state_nxt = SETTLE;
                SETTLE:     if (phase_last) state_nxt = (window_l == '0) ? DONE : SAMPLE;
                SAMPLE:     if (phase_last) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == HOLD) || (state == SETTLE) || (state == SAMPLE);
        done = (state == DONE);
    end

    assign hold_entry = (state_nxt == HOLD) && (state != HOLD);
    assign done_entry = (state_nxt == DONE) && (state != DONE);

    always_comb begin
        for (int i = 0; i < N; i++)
            mismatch_nxt[i] = (state == SAMPLE) ? sat_inc(mismatch[i], s_p1[i] ^ s_p1[0]) : mismatch[i];
    end

    // Control and run registers; the live run works from values latched on HOLD entry
    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            ising_rstn <= 1'b0;
            phase_cnt  <= '0;
            settle_r   <= CNT_W'(256);
            window_r   <= CNT_W'(1024);
            settle_l   <= '0;
            window_l   <= '0;
            spins      <= '0;
            for (int i = 0; i < N; i++) mismatch[i] <= '0;
        end else begin
            ising_rstn <= (state_nxt == SETTLE) || (state_nxt == SAMPLE) || (state_nxt == DONE);
            phase_cnt  <= (state_nxt != state) ? '0 : phase_cnt + CNT_W'(1);
            if (wready && wr_sel && wr_off == 10'h001) settle_r <= wdata[CNT_W-1:0];
            if (wready && wr_sel && wr_off == 10'h002) window_r <= wdata[CNT_W-1:0];
            if (hold_entry) begin
                settle_l <= settle_r;
                window_l <= window_r;
            end
            for (int i = 0; i < N; i++) mismatch[i] <= hold_entry ? '0 : mismatch_nxt[i];
            if (hold_entry) spins <= '0;
            else if (done_entry)
                for (int i = 0; i < N; i++) spins[i] <= (mismatch_nxt[i] > (window_l >> 1));
        end
    end

`ifdef READOUT_SNAPSHOT_EN
    logic [N-1:0] snap;
    always_ff @(posedge clk) begin
        if (!axi_rstn) snap <= '0;
        else if ((state == SAMPLE && state_nxt != SAMPLE) || (state == SETTLE && state_nxt == DONE))
            snap <= s_p1;
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (rd_sel) begin
            case (rd_off)
                10'h000: rd_mux = {30'b0, busy, done};
                10'h001: rd_mux = 32'(settle_r);
                10'h002: rd_mux = 32'(window_r);
                10'h003: rd_mux = 32'(spins);
`ifdef READOUT_SNAPSHOT_EN
                10'h004: rd_mux = 32'(snap);
`endif
                default: rd_mux = '0;
            endcase
            for (int i = 0; i < N; i++)
                if (rd_off == 10'(256 + i)) rd_mux = 32'(mismatch[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!axi_rstn) rdata <= '0;
        else           rdata <= rd_mux;
    end

endmodule

// File: tb/tb_spin_readout.sv
// Scoreboard bench for spin_readout: randomized oscillator stimulus against a cycle-history model.
// SNAP expectations follow READOUT_SNAPSHOT_EN.
`ifndef READOUT_ADDR_MASK
`define READOUT_ADDR_MASK 8'h43
`endif

module tb_spin_readout;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         axi_rstn, wready;
    logic [31:0]  wr_addr, wdata, rd_addr, rdata, rdata4;
    logic [N-1:0] osc_in = '0;
    logic         ising_rstn, ising_rstn4;

    always #5 clk = ~clk;

    spin_readout #(.N(N), .CNT_W(16)) dut (
        .clk(clk), .axi_rstn(axi_rstn), .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .rd_addr(rd_addr), .rdata(rdata), .osc_in(osc_in), .ising_rstn(ising_rstn));

    spin_readout #(.N(N), .CNT_W(4)) dut4 (
        .clk(clk), .axi_rstn(axi_rstn), .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .rd_addr(rd_addr), .rdata(rdata4), .osc_in(osc_in), .ising_rstn(ising_rstn4));

    typedef struct {
        string       nm;
        bit          sel;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t         sbq[$];
    int           vectors = 0, miscompares = 0, cyc = 0;
    logic         rd_vld = 1'b0, rd_vld_d = 1'b0;
    int           mode = 1;
    logic         src = 1'b0;
    logic [N-1:0] pol = '0, cval = '0;
    logic [N-1:0] hist [int];
    int           settle_m = 256, window_m = 1024;

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator source: value applied during cycle k is recorded as hist[k]
    always @(posedge clk) begin
        #1;
        case (mode)
            0: osc_in = N'($urandom);
            1: begin src = ~src; osc_in = {N{src}} ^ pol; end
            default: osc_in = cval;
        endcase
        hist[cyc] = osc_in;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] lo, input logic [31:0] hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h..0x%0h", nm, act, lo, hi);
        end
    endtask

    // Monitor: rdata is valid the cycle after a read was issued
    always @(posedge clk) rd_vld_d <= rd_vld;
    always @(negedge clk) begin
        if (rd_vld_d) begin : mon
            exp_t e;
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_underflow: got read data 0x%0h, expected no pending read", rdata);
            end else begin
                e = sbq.pop_front();
                check(e.nm, e.sel ? rdata4 : rdata, e.lo, e.hi);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        int guard = 0;
        while (cyc < c && guard < 5000) begin
            tick();
            guard++;
        end
        check("goto_cycle", cyc, c, c);
    endtask

    task automatic wr(input logic [9:0] off, input logic [31:0] d, output int wc);
        wready  = 1'b1;
        wr_addr = {`READOUT_ADDR_MASK, 12'b0, off, 2'b0};
        wdata   = d;
        wc      = cyc;
        if (off == 10'h001) settle_m = int'(d[15:0]);
        if (off == 10'h002) window_m = int'(d[15:0]);
        tick();
        wready = 1'b0;
    endtask

    task automatic rd(input logic [9:0] off, input string nm, input logic [31:0] lo,
                      input logic [31:0] hi, input bit sel = 1'b0);
        exp_t e;
        rd_addr = {`READOUT_ADDR_MASK, 12'b0, off, 2'b0};
        rd_vld  = 1'b1;
        e.nm = nm; e.sel = sel; e.lo = lo; e.hi = hi;
        sbq.push_back(e);
        tick();
        rd_vld = 1'b0;
    endtask

    // Counts SAMPLE cycles in [from,to] where the synchronized osc i differed from osc 0
    function automatic int count_mm(input int from, input int to, input int i);
        int n = 0;
        for (int c = from; c <= to; c++)
            if (hist[c-2][i] != hist[c-2][0]) n++;
        return n;
    endfunction

    task automatic do_run(input string tag, input int busy_win);
        int w, d, sp, wn, t_end;
        int mm [N];
        logic [N-1:0] sp_exp, snap_exp;
        sp = (settle_m == 0) ? 1 : settle_m;
        wn = window_m;
        wr(10'h000, 32'h1, w);
        check({tag, "_hold_rstn"}, 32'(ising_rstn), 0, 0);
        if (busy_win >= 0) wr(10'h002, busy_win, d);
        rd(10'h000, {tag, "_busy"}, 2, 2);
        t_end = w + 4 + sp + wn;
        goto(t_end);
        rd(10'h000, {tag, "_ctrl_last"}, 2, 2);
        rd(10'h000, {tag, "_done"}, 1, 1);
        check({tag, "_done_rstn"}, 32'(ising_rstn), 1, 1);
        for (int i = 0; i < N; i++) begin
            mm[i]     = count_mm(w + 5 + sp, t_end, i);
            sp_exp[i] = (mm[i] > (wn >> 1));
            rd(10'(256 + i), $sformatf("%s_mm%0d", tag, i), mm[i], mm[i]);
        end
        rd(10'h003, {tag, "_spins"}, 32'(sp_exp), 32'(sp_exp));
`ifdef READOUT_SNAPSHOT_EN
        snap_exp = hist[t_end - 2];
`else
        snap_exp = '0;
`endif
        rd(10'h004, {tag, "_snap"}, 32'(snap_exp), 32'(snap_exp));
    endtask

    initial begin
        int w, a, d;
        axi_rstn = 1'b0; wready = 1'b0; wr_addr = '0; wdata = '0; rd_addr = '0;
        tick(); tick();
        check("rst_rdata", rdata, 0, 0);
        check("rst_ising_rstn", 32'(ising_rstn), 0, 0);
        axi_rstn = 1'b1;
        rd(10'h001, "rst_settle", 256, 256);
        rd(10'h002, "rst_window", 1024, 1024);
        rd(10'h000, "rst_ctrl", 0, 0);
        rd(10'h003, "rst_spins", 0, 0);
        rd(10'h103, "rst_mm3", 0, 0);
        rd(10'h004, "rst_snap", 0, 0);

        // In-phase toggling source; WINDOW rewritten mid-run must not affect this run
        mode = 1; pol = '0;
        wr(10'h001, 10, d);
        wr(10'h002, 100, d);
        do_run("inphase", 7);
        rd(10'h002, "window_after_busy_wr", 7, 7);

        pol = 8'h08;
        wr(10'h002, 100, d);
        do_run("anti", -1);

        wr(10'h001, 0, d);
        wr(10'h002, 0, d);
        do_run("w0", -1);
        rd(10'h108, "mm_out_of_range", 0, 0);
        rd(10'h005, "unmapped", 0, 0);

        // Narrow-counter instance runs in lockstep on the shared bus
        pol = 8'h02;
        wr(10'h001, 3, d);
        wr(10'h002, 15, d);
        do_run("sat", -1);
        rd(10'h101, "sat4_mm1", 15, 15, 1'b1);
        rd(10'h003, "sat4_spins", 32'h02, 32'h02, 1'b1);
        rd(10'h002, "sat4_window", 15, 15, 1'b1);

        mode = 0;
        for (int k = 0; k < 4; k++) begin
            wr(10'h001, $urandom_range(0, 12), d);
            wr(10'h002, $urandom_range(0, 40), d);
            do_run($sformatf("rand%0d", k), -1);
        end

        // Abort mid-SAMPLE after an ignored start during SETTLE
        mode = 1; pol = 8'h20;
        wr(10'h001, 10, d);
        wr(10'h002, 100, d);
        wr(10'h000, 32'h1, w);
        goto(w + 7);
        wr(10'h000, 32'h1, d);
        goto(w + 35);
        wr(10'h000, 32'h2, a);
        check("abort_rstn", 32'(ising_rstn), 0, 0);
        rd(10'h000, "abort_ctrl", 0, 0);
        rd(10'h105, "abort_mm5", count_mm(w + 15, a, 5), count_mm(w + 15, a, 5));
        wr(10'h000, 32'h3, d);
        check("abort_start_rstn", 32'(ising_rstn), 0, 0);
        rd(10'h000, "abort_start_ctrl", 0, 0);
        do_run("restart", -1);

        mode = 2; cval = 8'hA5;
        wr(10'h001, 2, d);
        wr(10'h002, 5, d);
        do_run("snap", -1);

        // Reset mid-run
        wr(10'h000, 32'h1, w);
        tick(); tick();
        axi_rstn = 1'b0;
        tick();
        check("midrst_rstn", 32'(ising_rstn), 0, 0);
        check("midrst_rdata", rdata, 0, 0);
        axi_rstn = 1'b1;
        settle_m = 256; window_m = 1024;
        rd(10'h001, "midrst_settle", 256, 256);
        rd(10'h002, "midrst_window", 1024, 1024);
        rd(10'h000, "midrst_ctrl", 0, 0);
        rd(10'h101, "midrst_mm1", 0, 0);
        rd(10'h003, "midrst_spins", 0, 0);

        tick(); tick();
        check("sb_drained", sbq.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
